// File: rtl/fp_mant_addsub_norm_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_mant_addsub_norm_pipe                                                  |
// | Three-stage elastic mantissa add/sub, leading-zero count and normalise.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fp_mant_addsub_norm_pipe #(
  parameter  int MAN_W   = 23,
  parameter  int GUARD_W = 8,
  localparam int SUM_W   = MAN_W + GUARD_W + 2,
  localparam int SH_W    = $clog2(SUM_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] mmax,
  input  logic [MAN_W:0]   mmin,
  input  logic             sa,
  input  logic             sb,
  input  logic             max_ab,
  input  logic             op_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum_norm,
  output logic [SH_W-1:0]  shift,
  output logic             psgn,
  output logic             opr,
  output logic             zero
);

  logic             s1_valid_q, s1_valid_d;
  logic [SUM_W-1:0] s1_sum_q,   s1_sum_d;
  logic             s1_psgn_q,  s1_psgn_d;
  logic             s1_opr_q,   s1_opr_d;

  logic             s2_valid_q, s2_valid_d;
  logic [SUM_W-1:0] s2_sum_q,   s2_sum_d;
  logic [SH_W-1:0]  s2_shift_q, s2_shift_d;
  logic             s2_zero_q,  s2_zero_d;
  logic             s2_psgn_q,  s2_psgn_d;
  logic             s2_opr_q,   s2_opr_d;

  logic             s3_valid_q, s3_valid_d;
  logic [SUM_W-1:0] s3_sum_q,   s3_sum_d;
  logic [SH_W-1:0]  s3_shift_q, s3_shift_d;
  logic             s3_zero_q,  s3_zero_d;
  logic             s3_psgn_q,  s3_psgn_d;
  logic             s3_opr_q,   s3_opr_d;

  logic             w_acc1, w_acc2, w_acc3;
  logic [SUM_W-1:0] w_op_a, w_op_b, w_sum;
  logic             w_opr;
  logic [SH_W-1:0]  w_lz;

  // A stage can take a new item when it is empty or its content moves on this cycle.
  assign w_acc3   = ~s3_valid_q | out_ready;
  assign w_acc2   = ~s2_valid_q | w_acc3;
  assign w_acc1   = ~s1_valid_q | w_acc2;
  assign in_ready = w_acc1;

  always_comb begin
    w_op_a = {1'b0, 1'b1, mmax, {GUARD_W{1'b0}}};
    w_op_b = {1'b0, mmin, {GUARD_W{1'b0}}};
    w_opr  = op_mode ^ sa ^ sb;
    w_sum  = w_opr ? (w_op_a - w_op_b) : (w_op_a + w_op_b);

    // Last set bit scanning upward wins, leaving the most significant one.
    w_lz = SH_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (s1_sum_q[i]) w_lz = SH_W'(SUM_W - 1 - i);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_psgn_d  = s1_psgn_q;
    s1_opr_d   = s1_opr_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_shift_d = s2_shift_q;
    s2_zero_d  = s2_zero_q;
    s2_psgn_d  = s2_psgn_q;
    s2_opr_d   = s2_opr_q;
    s3_valid_d = s3_valid_q;
    s3_sum_d   = s3_sum_q;
    s3_shift_d = s3_shift_q;
    s3_zero_d  = s3_zero_q;
    s3_psgn_d  = s3_psgn_q;
    s3_opr_d   = s3_opr_q;

    if (w_acc1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d  = w_sum;
        s1_psgn_d = max_ab ? sb : sa;
        s1_opr_d  = w_opr;
      end
    end

    if (w_acc2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_d   = s1_sum_q;
        s2_shift_d = w_lz;
        s2_zero_d  = (s1_sum_q == '0);
        s2_psgn_d  = s1_psgn_q;
        s2_opr_d   = s1_opr_q;
      end
    end

    if (w_acc3) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_sum_d   = s2_sum_q << s2_shift_q;
        s3_shift_d = s2_shift_q;
        s3_zero_d  = s2_zero_q;
        s3_psgn_d  = s2_psgn_q;
        s3_opr_d   = s2_opr_q;
      end
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s3_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_psgn_q  <= 1'b0;
      s1_opr_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_shift_q <= '0;
      s2_zero_q  <= 1'b0;
      s2_psgn_q  <= 1'b0;
      s2_opr_q   <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_sum_q   <= '0;
      s3_shift_q <= '0;
      s3_zero_q  <= 1'b0;
      s3_psgn_q  <= 1'b0;
      s3_opr_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_psgn_q  <= s1_psgn_d;
      s1_opr_q   <= s1_opr_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_shift_q <= s2_shift_d;
      s2_zero_q  <= s2_zero_d;
      s2_psgn_q  <= s2_psgn_d;
      s2_opr_q   <= s2_opr_d;
      s3_valid_q <= s3_valid_d;
      s3_sum_q   <= s3_sum_d;
      s3_shift_q <= s3_shift_d;
      s3_zero_q  <= s3_zero_d;
      s3_psgn_q  <= s3_psgn_d;
      s3_opr_q   <= s3_opr_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign sum_norm  = s3_sum_q;
  assign shift     = s3_shift_q;
  assign psgn      = s3_psgn_q;
  assign opr       = s3_opr_q;
  assign zero      = s3_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mant_addsub_norm_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_mant_addsub_norm_pipe                                               |
// | Directed bench for the mantissa add/sub/normalise pipe, two sizings.      |
// | Rev 1.1                                                                   |
// +--------------------------------------------------------------------------+
module tb_fp_mant_addsub_norm_pipe;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic [22:0] a_mmax = '0;
    logic [23:0] a_mmin = '0;
    logic        a_sa = 1'b0, a_sb = 1'b0, a_max_ab = 1'b0, a_op = 1'b0;
    logic [32:0] a_sum;
    logic [5:0]  a_shift;
    logic        a_psgn, a_opr, a_zero;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [9:0]  b_mmax = '0;
    logic [10:0] b_mmin = '0;
    logic        b_sa = 1'b0, b_sb = 1'b0, b_max_ab = 1'b0, b_op = 1'b0;
    logic [14:0] b_sum;
    logic [3:0]  b_shift;
    logic        b_psgn, b_opr, b_zero;

    fp_mant_addsub_norm_pipe #(.MAN_W(23), .GUARD_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mmax(a_mmax), .mmin(a_mmin), .sa(a_sa), .sb(a_sb),
        .max_ab(a_max_ab), .op_mode(a_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sum_norm(a_sum), .shift(a_shift), .psgn(a_psgn), .opr(a_opr), .zero(a_zero)
    );

    fp_mant_addsub_norm_pipe #(.MAN_W(10), .GUARD_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mmax(b_mmax), .mmin(b_mmin), .sa(b_sa), .sb(b_sb),
        .max_ab(b_max_ab), .op_mode(b_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sum_norm(b_sum), .shift(b_shift), .psgn(b_psgn), .opr(b_opr), .zero(b_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input string tag, input logic [22:0] mm, input logic [23:0] mn,
                          input logic s_a, input logic s_b, input logic mab, input logic op,
                          input logic [32:0] e_sum, input logic [5:0] e_sh,
                          input logic e_psgn, input logic e_opr, input logic e_zero);
        int lat;
        a_mmax = mm; a_mmin = mn; a_sa = s_a; a_sb = s_b; a_max_ab = mab; a_op = op;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/wait_expired"}, a_out_valid, 1'b1);
        check({tag, "/latency"}, lat, 3);
        check({tag, "/sum_norm"}, a_sum, e_sum);
        check({tag, "/shift"}, a_shift, e_sh);
        check({tag, "/psgn"}, a_psgn, e_psgn);
        check({tag, "/opr"}, a_opr, e_opr);
        check({tag, "/zero"}, a_zero, e_zero);
        @(posedge clk); #1;
    endtask

    task automatic send_b(input string tag, input logic [9:0] mm, input logic [10:0] mn,
                          input logic s_a, input logic s_b, input logic mab, input logic op,
                          input logic [14:0] e_sum, input logic [3:0] e_sh,
                          input logic e_psgn, input logic e_opr, input logic e_zero);
        int lat;
        b_mmax = mm; b_mmin = mn; b_sa = s_a; b_sb = s_b; b_max_ab = mab; b_op = op;
        b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/wait_expired"}, b_out_valid, 1'b1);
        check({tag, "/latency"}, lat, 3);
        check({tag, "/sum_norm"}, b_sum, e_sum);
        check({tag, "/shift"}, b_shift, e_sh);
        check({tag, "/psgn"}, b_psgn, e_psgn);
        check({tag, "/opr"}, b_opr, e_opr);
        check({tag, "/zero"}, b_zero, e_zero);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [32:0] held_sum;
        logic [5:0]  held_sh;
        logic        seen;
        logic        acc;
        int          accepted;
        int          received;
        int          cyc;

        #12;
        check("por/out_valid", a_out_valid, 1'b0);
        check("por/sum_norm", a_sum, 33'h0);
        check("por/shift", a_shift, 6'h0);
        check("por/b_out_valid", b_out_valid, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("por/in_ready", a_in_ready, 1'b1);

        send_a("a_add",    23'h0,      24'h800000, 1'b0, 1'b0, 1'b0, 1'b0,
               33'h1_0000_0000, 6'd0,  1'b0, 1'b0, 1'b0);
        send_a("a_cancel", 23'h0,      24'h800000, 1'b0, 1'b0, 1'b0, 1'b1,
               33'h0,           6'd33, 1'b0, 1'b1, 1'b1);
        send_a("a_deep",   23'h000001, 24'h800000, 1'b1, 1'b1, 1'b1, 1'b1,
               33'h1_0000_0000, 6'd24, 1'b1, 1'b1, 1'b0);
        send_b("b_add",    10'h0,      11'h400,    1'b0, 1'b0, 1'b0, 1'b0,
               15'h4000,        4'd0,  1'b0, 1'b0, 1'b0);
        send_b("b_cancel", 10'h0,      11'h400,    1'b0, 1'b0, 1'b0, 1'b1,
               15'h0,           4'd15, 1'b0, 1'b1, 1'b1);
        send_b("b_deep",   10'h001,    11'h400,    1'b1, 1'b1, 1'b1, 1'b1,
               15'h4000,        4'd11, 1'b1, 1'b1, 1'b0);

        a_mmin = '0; a_sa = 1'b0; a_sb = 1'b0; a_max_ab = 1'b0; a_op = 1'b0;
        accepted = 0; received = 0; held_sum = '0; held_sh = '0;
        for (cyc = 0; cyc < 60 && received < 6; cyc++) begin
            a_in_valid  = (accepted < 6);
            a_mmax      = 23'(accepted + 1);
            a_out_ready = (cyc >= 5);
            #1;
            acc = a_in_valid & a_in_ready;
            if (cyc == 3) begin
                check("bp/accepted_before_stall", accepted, 3);
                check("bp/in_ready_stalled", a_in_ready, 1'b0);
                held_sum = a_sum;
                held_sh  = a_shift;
            end
            if (cyc == 4) begin
                check("bp/stall_valid", a_out_valid, 1'b1);
                check("bp/stall_sum_stable", a_sum, held_sum);
                check("bp/stall_shift_stable", a_shift, held_sh);
            end
            if (a_out_valid && a_out_ready) begin
                received++;
                check("bp/order_sum", a_sum, 33'h1_0000_0000 + (33'(received) << 9));
                check("bp/order_shift", a_shift, 6'd1);
            end
            @(posedge clk); #1;
            if (acc) accepted++;
        end
        a_in_valid = 1'b0;
        check("bp/received", received, 6);
        check("bp/accepted", accepted, 6);

        a_out_ready = 1'b0;
        a_mmax = 23'h0; a_mmin = 24'h800000; a_op = 1'b1;
        a_in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("flush/full_valid", a_out_valid, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        check("flush/out_valid_cleared", a_out_valid, 1'b0);
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; seen |= a_out_valid; end
        check("flush/none_appear", seen, 1'b0);

        a_in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush/in_ready_empty", a_in_ready, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0; a_in_valid = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= a_out_valid; end
        check("flush/input_dropped", seen, 1'b0);

        a_out_ready = 1'b0;
        a_mmax = 23'h000001; a_mmin = 24'h800000; a_sa = 1'b1; a_sb = 1'b1;
        a_max_ab = 1'b1; a_op = 1'b1;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
        a_in_valid = 1'b0;
        check("rst/pre_valid", a_out_valid, 1'b1);
        check("rst/pre_psgn", a_psgn, 1'b1);
        #2; rst = 1'b0; #1;
        check("rst/out_valid", a_out_valid, 1'b0);
        check("rst/sum_norm", a_sum, 33'h0);
        check("rst/shift", a_shift, 6'h0);
        check("rst/psgn", a_psgn, 1'b0);
        check("rst/opr", a_opr, 1'b0);
        check("rst/zero", a_zero, 1'b0);
        @(negedge clk); rst = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst/in_ready_after", a_in_ready, 1'b1);
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= a_out_valid; end
        check("rst/no_stale", seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
